// File: rtl/width_serializer_pkg.sv
// Shared helpers for the width serializer: slice arithmetic, legality check
// and the derived occupancy state used for debug visibility.
package width_serializer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } ser_state_e;

  function automatic int slice_count(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int in_w, input int out_w);
    return (out_w > 0) && (in_w >= out_w) && ((in_w % out_w) == 0);
  endfunction

endpackage

// File: rtl/width_serializer_chk.sv
// Elaboration-time legality check of the serializer width parameters.
module width_serializer_chk
  import width_serializer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2
) ();

  if (!params_legal(IN_W, OUT_W)) begin : g_illegal
    $error("width_serializer: IN_W must be a non-zero multiple of OUT_W");
  end

endmodule

// File: rtl/width_serializer_hold.sv
// Single-entry holding register with valid/ready; a load in the same cycle
// as an unload replaces the entry, so it also works as a pass-through stage.
module width_serializer_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         din_last,
  input  logic         unload,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         dout_last
);

  logic         valid_r;
  logic [W-1:0] data_r;
  logic         last_r;

  // entry storage: load has priority, unload empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      last_r  <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= din;
      last_r  <= din_last;
    end else if (unload) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign ready     = !valid_r;
  assign valid     = valid_r;
  assign dout      = data_r;
  assign dout_last = last_r;

endmodule

// File: rtl/width_serializer.sv
// Wide-to-narrow stream serializer: IN_W-bit words out as OUT_W-bit slices,
// with backpressure, a one-word holding buffer and end-of-frame propagation.
module width_serializer
  import width_serializer_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             axiiv,
  input  logic [IN_W-1:0]  axiid,
  input  logic             axiil,
  output logic             axiir,
  output logic             axiov,
  output logic [OUT_W-1:0] axiod,
  output logic             axiol,
  input  logic             axior
);

  localparam int N  = slice_count(IN_W, OUT_W);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  width_serializer_chk #(.IN_W(IN_W), .OUT_W(OUT_W)) u_chk ();

  logic [IN_W-1:0] sh_data_r, sh_data_s, shifted_s;
  logic            sh_last_r, sh_last_s;
  logic            sh_valid_r, sh_valid_s;
  logic [CW-1:0]   slice_cnt_r, slice_cnt_s;

  logic            hd_ready_s, hd_valid_s, hd_last_s;
  logic [IN_W-1:0] hd_data_s;

  logic            accept_s, consume_s, final_s, hd_load_s, hd_unload_s;
  ser_state_e      state_s;

  // handshake qualifiers and derived occupancy state
  always_comb begin
    accept_s    = axiiv && hd_ready_s;
    consume_s   = sh_valid_r && axior;
    final_s     = consume_s && (slice_cnt_r == LAST_CNT);
    hd_load_s   = accept_s && sh_valid_r && !final_s;
    hd_unload_s = final_s && hd_valid_s;
    if (!sh_valid_r) begin
      state_s = ST_EMPTY;
    end else if (!hd_valid_s) begin
      state_s = ST_BUSY;
    end else begin
      state_s = ST_FULL;
    end
  end

  width_serializer_hold #(.W(IN_W)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hd_load_s),
    .din       (axiid),
    .din_last  (axiil),
    .unload    (hd_unload_s),
    .ready     (hd_ready_s),
    .valid     (hd_valid_s),
    .dout      (hd_data_s),
    .dout_last (hd_last_s)
  );

  // next state of the active shift register
  always_comb begin
    sh_data_s   = sh_data_r;
    sh_last_s   = sh_last_r;
    sh_valid_s  = sh_valid_r;
    slice_cnt_s = slice_cnt_r;
    if (MSB_FIRST) begin
      shifted_s = sh_data_r << OUT_W;
    end else begin
      shifted_s = sh_data_r >> OUT_W;
    end
    case (state_s)
      ST_EMPTY: begin
        if (accept_s) begin
          sh_data_s   = axiid;
          sh_last_s   = axiil;
          sh_valid_s  = 1'b1;
          slice_cnt_s = '0;
        end else begin
          sh_valid_s  = 1'b0;
        end
      end
      ST_BUSY, ST_FULL: begin
        if (final_s) begin
          slice_cnt_s = '0;
          // holding word first; bypass only when the buffer is empty
          if (hd_valid_s) begin
            sh_data_s = hd_data_s;
            sh_last_s = hd_last_s;
          end else if (accept_s) begin
            sh_data_s = axiid;
            sh_last_s = axiil;
          end else begin
            sh_valid_s = 1'b0;
          end
        end else if (consume_s) begin
          sh_data_s   = shifted_s;
          slice_cnt_s = slice_cnt_r + CW'(1);
        end else begin
          slice_cnt_s = slice_cnt_r;
        end
      end
      default: begin
        sh_valid_s  = 1'b0;
        slice_cnt_s = '0;
      end
    endcase
  end

  // active shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data_r   <= '0;
      sh_last_r   <= 1'b0;
      sh_valid_r  <= 1'b0;
      slice_cnt_r <= '0;
    end else begin
      sh_data_r   <= sh_data_s;
      sh_last_r   <= sh_last_s;
      sh_valid_r  <= sh_valid_s;
      slice_cnt_r <= slice_cnt_s;
    end
  end

  if (MSB_FIRST) begin : g_msb
    assign axiod = sh_data_r[IN_W-1 -: OUT_W];
  end else begin : g_lsb
    assign axiod = sh_data_r[OUT_W-1:0];
  end

  assign axiir = hd_ready_s;
  assign axiov = sh_valid_r;
  assign axiol = sh_valid_r && sh_last_r && (slice_cnt_r == LAST_CNT);

endmodule

// File: tb/tb_width_serializer.sv
// Directed bench for width_serializer across four parameter sets.
module tb_width_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: 8->2 LSB-first, b: 8->2 MSB-first, c: 32->8 MSB-first, d: 8->8
  logic       a_iv, a_il, a_ir, a_ov, a_ol, a_or;
  logic [7:0] a_id;
  logic [1:0] a_od;
  logic       b_iv, b_il, b_ir, b_ov, b_ol, b_or;
  logic [7:0] b_id;
  logic [1:0] b_od;
  logic        c_iv, c_il, c_ir, c_ov, c_ol, c_or;
  logic [31:0] c_id;
  logic [7:0]  c_od;
  logic       d_iv, d_il, d_ir, d_ov, d_ol, d_or;
  logic [7:0] d_id;
  logic [7:0] d_od;

  width_serializer #(.IN_W(8), .OUT_W(2), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .axiiv(a_iv), .axiid(a_id), .axiil(a_il), .axiir(a_ir),
    .axiov(a_ov), .axiod(a_od), .axiol(a_ol), .axior(a_or));
  width_serializer #(.IN_W(8), .OUT_W(2), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .axiiv(b_iv), .axiid(b_id), .axiil(b_il), .axiir(b_ir),
    .axiov(b_ov), .axiod(b_od), .axiol(b_ol), .axior(b_or));
  width_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .axiiv(c_iv), .axiid(c_id), .axiil(c_il), .axiir(c_ir),
    .axiov(c_ov), .axiod(c_od), .axiol(c_ol), .axior(c_or));
  width_serializer #(.IN_W(8), .OUT_W(8), .MSB_FIRST(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .axiiv(d_iv), .axiid(d_id), .axiil(d_il), .axiir(d_ir),
    .axiov(d_ov), .axiod(d_od), .axiol(d_ol), .axior(d_or));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_lsb [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] exp_msb [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [7:0] exp_w32 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] bw      [3] = '{8'hB4, 8'h1E, 8'hFF};
  logic [1:0] bexp   [12] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00,
                               2'b11, 2'b11, 2'b11, 2'b11};
  logic [7:0] cw      [3] = '{8'h96, 8'h5A, 8'hC3};
  logic [1:0] cexp   [12] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01,
                               2'b11, 2'b00, 2'b00, 2'b11};
  logic [1:0] exp_3c  [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
  logic [7:0] dw      [3] = '{8'h11, 8'h22, 8'h33};
  logic       dl      [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int  w;
    int  got;
    bit  acc;
    a_iv = 1'b0; a_id = 8'h00; a_il = 1'b0; a_or = 1'b1;
    b_iv = 1'b0; b_id = 8'h00; b_il = 1'b0; b_or = 1'b1;
    c_iv = 1'b0; c_id = 32'h0; c_il = 1'b0; c_or = 1'b1;
    d_iv = 1'b0; d_id = 8'h00; d_il = 1'b0; d_or = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_ready", a_ir, 1'b1);
    chk("rst_valid", a_ov, 1'b0);
    chk("rst_last", a_ol, 1'b0);
    chk("rst_data", a_od, 2'b00);
    chk("rst_ready_w32", c_ir, 1'b1);

    // single word on all four instances
    a_iv = 1'b1; a_id = 8'hB4; a_il = 1'b1;
    b_iv = 1'b1; b_id = 8'hB4; b_il = 1'b1;
    c_iv = 1'b1; c_id = 32'hDEADBEEF; c_il = 1'b1;
    d_iv = 1'b1; d_id = 8'hB4; d_il = 1'b1;
    tick();
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; d_iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lsb_v%0d", k), a_ov, 1'b1);
      chk($sformatf("lsb_d%0d", k), a_od, exp_lsb[k]);
      chk($sformatf("lsb_l%0d", k), a_ol, (k == 3));
      chk($sformatf("msb_d%0d", k), b_od, exp_msb[k]);
      chk($sformatf("msb_l%0d", k), b_ol, (k == 3));
      chk($sformatf("w32_d%0d", k), c_od, exp_w32[k]);
      chk($sformatf("w32_l%0d", k), c_ol, (k == 3));
      if (k == 0) begin
        chk("n1_v0", d_ov, 1'b1);
        chk("n1_d0", d_od, 8'hB4);
        chk("n1_l0", d_ol, 1'b1);
      end
      if (k == 1) chk("n1_v1", d_ov, 1'b0);
      tick();
    end
    chk("lsb_idle", a_ov, 1'b0);
    chk("msb_idle", b_ov, 1'b0);
    chk("w32_idle", c_ov, 1'b0);

    // back-to-back words with valid held
    w = 0;
    for (int c = 0; c < 13; c++) begin
      a_iv = (w < 3);
      a_id = bw[(w < 3) ? w : 0];
      a_il = (w == 2);
      acc  = a_iv && a_ir;
      tick();
      if (acc) w++;
      if (c < 12) begin
        chk($sformatf("b2b_v%0d", c), a_ov, 1'b1);
        chk($sformatf("b2b_d%0d", c), a_od, bexp[c]);
        chk($sformatf("b2b_l%0d", c), a_ol, (c == 11));
      end else begin
        chk("b2b_end", a_ov, 1'b0);
      end
    end
    a_iv = 1'b0;
    chk("b2b_acc", w, 3);

    // backpressure mid-word while two more words are offered
    w = 0;
    got = 0;
    for (int c = 0; c < 24 && got < 12; c++) begin
      a_or = !(c >= 2 && c <= 4);
      if (c >= 2 && c <= 5) begin
        chk($sformatf("bp_frz_v%0d", c), a_ov, 1'b1);
        chk($sformatf("bp_frz_d%0d", c), a_od, 2'b01);
        chk($sformatf("bp_frz_l%0d", c), a_ol, 1'b0);
      end
      if (c == 2) chk("bp_ready_drop", a_ir, 1'b0);
      a_iv = (w < 3);
      a_id = cw[(w < 3) ? w : 0];
      a_il = (w == 2);
      acc  = a_iv && a_ir;
      if (a_ov && a_or) begin
        chk($sformatf("bp_d%0d", got), a_od, cexp[got]);
        chk($sformatf("bp_l%0d", got), a_ol, (got == 11));
        got++;
      end
      tick();
      if (acc) w++;
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    chk("bp_count", got, 12);
    chk("bp_acc", w, 3);
    tick();

    // asynchronous reset during slice 2
    a_iv = 1'b1; a_id = 8'hB4; a_il = 1'b1;
    tick();
    a_iv = 1'b0;
    tick();
    tick();
    chk("rst_pre_d", a_od, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_v", a_ov, 1'b0);
    chk("arst_d", a_od, 2'b00);
    chk("arst_l", a_ol, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_v", a_ov, 1'b0);
    chk("post_rst_r", a_ir, 1'b1);
    a_iv = 1'b1; a_id = 8'h3C; a_il = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w3c_v%0d", k), a_ov, 1'b1);
      chk($sformatf("w3c_d%0d", k), a_od, exp_3c[k]);
      chk($sformatf("w3c_l%0d", k), a_ol, (k == 3));
      tick();
    end
    chk("w3c_end", a_ov, 1'b0);

    // N=1: full throughput, last follows each word
    w = 0;
    for (int c = 0; c < 4; c++) begin
      d_iv = (w < 3);
      d_id = dw[(w < 3) ? w : 0];
      d_il = dl[(w < 3) ? w : 0];
      acc  = d_iv && d_ir;
      tick();
      if (acc) w++;
      if (c < 3) begin
        chk($sformatf("n1_bb_v%0d", c), d_ov, 1'b1);
        chk($sformatf("n1_bb_d%0d", c), d_od, dw[c]);
        chk($sformatf("n1_bb_l%0d", c), d_ol, dl[c]);
      end else begin
        chk("n1_bb_end", d_ov, 1'b0);
      end
    end
    d_iv = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
